// File: rtl/imem_pkg.sv
// Shared defaults, FSM state encoding and counter-width helper for the
// instruction-memory responder slice.
package imem_pkg;

   localparam int unsigned DATA_W_DEF = 20;
   localparam int unsigned ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      READ = 2'd2,
      RESP = 2'd3
   } state_e;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response, flush and loader-write signals between the fetch
// unit (master) and the instruction-memory responder (slave).
interface imem_responder_if import imem_pkg::*; #(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              flush;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/imem_responder_array.sv
// DEPTH x DATA_W instruction storage: synchronous write, registered
// read-before-write read port, no reset.
module imem_array import imem_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = 200
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Both updates are non-blocking, so a same-edge write is not seen by the read.
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed LATENCY edges
// from accept to rsp_valid, response held until taken, flushable.
module imem_responder import imem_pkg::*; #(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DEPTH   = 200,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   imem_responder_if.slave  bus
);

   localparam int unsigned CNT_W    = clog2(LATENCY);
   localparam int unsigned CNT_LOAD = (LATENCY > 1) ? (LATENCY - 2) : 0;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_BUSY = BUSY;
   localparam logic [1:0] S_READ = READ;
   localparam logic [1:0] S_RESP = RESP;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rd_ok_q, rd_ok_d;
   logic              req_ready;
   logic              rd_en;
   logic              in_range;
   logic [DATA_W-1:0] rd_data;

   assign in_range = (32'(addr_q) < DEPTH);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      req_ready   = 1'b0;
      rd_en       = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = !bus.flush;
            if (bus.req_valid && req_ready) begin
               addr_d = bus.req_addr;
               if (LATENCY == 1) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(CNT_LOAD);
               end
            end
         end
         S_BUSY: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_READ;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         // READ is the last latency cycle: the array registers the word on its exit edge.
         S_READ: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               rd_en       = in_range;
               rd_ok_d     = in_range;
               rsp_err_d   = !in_range;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         default: begin
            if (bus.flush || bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
      endcase

      if (bus.flush && (state_q != S_IDLE)) begin
         rsp_valid_d = 1'b0;
         rsp_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   imem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_en   (rd_en),
      .rd_addr (addr_q),
      .rd_data (rd_data)
   );

   // The array read register has no reset; rd_ok_q forces rsp_data to 0 after
   // reset and for out-of-range fetches.
   assign bus.rsp_data  = rd_ok_q ? rd_data : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.req_ready = req_ready;

endmodule
